// File: rtl/hs4_pkg.sv
// Shared constants for the four-phase handshake responder: FSM encoding and counter width.
package hs4_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACK_HI  = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/hs4_responder_if.sv
// Handshake port (req/data/ack) plus the outgoing valid/ready stream of the responder.
interface hs4_responder_if #(
  parameter int DATA_W = 8
);

  logic              req;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  req,
    input  data,
    input  out_ready,
    output ack,
    output out_valid,
    output out_data
  );

  modport master (
    output req,
    output data,
    output out_ready,
    input  ack,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous control bit, cleared by rst_n.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/hs4_responder.sv
// Four-phase req/ack responder: captures each word into a small FIFO and emits it on a
// valid/ready stream, counting completed handshakes and flagging requests withdrawn early.
module hs4_responder
  import hs4_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hs4_responder_if.slave        hs_if,
  output logic [XFER_CNT_W-1:0] xfer_cnt_o,
  output logic                  err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic                  req_s;
  logic [1:0]            state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  wait_q, wait_d;
  logic                  err_q, err_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  push, pop, full, empty;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (hs_if.req),
    .q_o  (req_s)
  );

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && hs_if.out_ready;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    wait_d     = wait_q;
    err_d      = err_q;
    xfer_cnt_d = xfer_cnt_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // A pop in the same cycle frees a slot, so a full FIFO can still accept.
          if (!full || pop) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            wait_d  = 1'b0;
            state_d = ST_ACK_HI;
          end else begin
            wait_d = 1'b1;
          end
        end else if (wait_q) begin
          err_d  = 1'b1;
          wait_d = 1'b0;
        end
      end
      ST_ACK_HI: begin
        if (!req_s) begin
          ack_d      = 1'b0;
          xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!req_s) begin
          ack_d      = 1'b0;
          xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      wait_q     <= 1'b0;
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage carries no reset; the output mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= hs_if.data;
    end
  end

  assign hs_if.ack       = ack_q;
  assign hs_if.out_valid = !empty;
  assign hs_if.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign xfer_cnt_o      = xfer_cnt_q;
  assign err_o           = err_q;

  a_ack_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(ack_q) |-> $past(req_s));

  a_push_only_ack_low: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !ack_q);

endmodule

// File: tb/tb_hs4_responder.sv
// Randomized self-checking bench for hs4_responder with a queue-based reference of accepted words.
module tb_hs4_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] xfer_cnt;
  logic        err;

  always #5 clk = ~clk;

  hs4_responder_if #(.DATA_W(8)) bus ();

  hs4_responder #(
    .DATA_W     (8),
    .DEPTH      (2),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hs_if     (bus.slave),
    .xfer_cnt_o(xfer_cnt),
    .err_o     (err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_err = 1'b0;
  bit          rnd_done;

  // Every word leaving the stream must be the oldest acknowledged word not yet delivered.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_order: out_data=%h popped but no word expected", bus.out_data);
      end else begin
        if (bus.out_data !== exp_q[0]) begin
          n_bad++;
          $display("FAIL pop_order: out_data=%h required %h", bus.out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_hs(input logic [7:0] d);
    int t;
    bus.data = d;
    bus.req  = 1'b1;
    t = 0;
    tick();
    while (bus.ack !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    n_cmp++;
    if (bus.ack !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_ack_rise: ack=%b required 1 for data %h", bus.ack, d);
      bus.req = 1'b0;
      return;
    end
    exp_q.push_back(d);
    bus.req = 1'b0;
    t = 0;
    while (bus.ack !== 1'b0 && t < 200) begin
      tick();
      t++;
    end
    n_cmp++;
    if (bus.ack !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_ack_fall: ack=%b required 0 for data %h", bus.ack, d);
      return;
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 1'b0;
    bus.data      = 8'h00;
    bus.out_ready = 1'b0;
    tick(3);
    n_cmp += 5;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: ack=%b required 0", bus.ack); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: out_valid=%b required 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: out_data=%h required 00", bus.out_data); end
    if (xfer_cnt !== 16'h0000) begin n_bad++; $display("FAIL rst_cnt: xfer_cnt=%h required 0000", xfer_cnt); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: err=%b required 0", err); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    bus.data = 8'hA5;
    bus.req  = 1'b1;
    tick();
    n_cmp++;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL basic_edge1: ack=%b required 0", bus.ack); end
    tick();
    n_cmp++;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL basic_edge2: ack=%b required 0", bus.ack); end
    tick();
    n_cmp += 3;
    if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL basic_edge3_ack: ack=%b required 1", bus.ack); end
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_edge3_valid: out_valid=%b required 1", bus.out_valid); end
    if (bus.out_data !== 8'hA5) begin n_bad++; $display("FAIL basic_edge3_data: out_data=%h required a5", bus.out_data); end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_popped: out_valid=%b required 0", bus.out_valid); end
    bus.req = 1'b0;
    tick(2);
    n_cmp++;
    if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL basic_ack_hold: ack=%b required 1", bus.ack); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_cmp += 2;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL basic_ack_fall: ack=%b required 0", bus.ack); end
    if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL basic_cnt: xfer_cnt=%h required %h", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int t;
    bus.out_ready = 1'b0;
    do_hs(8'h11);
    do_hs(8'h22);
    bus.data = 8'h33;
    bus.req  = 1'b1;
    tick(8);
    n_cmp += 3;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL bp_ack_held: ack=%b required 0", bus.ack); end
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: out_valid=%b required 1", bus.out_valid); end
    if (bus.out_data !== 8'h11) begin n_bad++; $display("FAIL bp_head: out_data=%h required 11", bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.ack !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ack_on_pop: ack=%b required 1", bus.ack);
    end else begin
      exp_q.push_back(8'h33);
    end
    bus.req = 1'b0;
    t = 0;
    while (bus.ack !== 1'b0 && t < 50) begin
      tick();
      t++;
    end
    exp_cnt = exp_cnt + 16'd1;
    tick(4);
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain: %0d words outstanding, required 0", exp_q.size()); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: out_valid=%b required 0", bus.out_valid); end
    if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt: xfer_cnt=%h required %h", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b0;
    do_hs(8'h11);
    do_hs(8'h22);
    bus.data = 8'h33;
    bus.req  = 1'b1;
    tick(6);
    n_cmp++;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack_pending: ack=%b required 0", bus.ack); end
    bus.req = 1'b0;
    tick(6);
    exp_err = 1'b1;
    n_cmp += 5;
    if (err !== exp_err) begin n_bad++; $display("FAIL abort_err: err=%b required %b", err, exp_err); end
    if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL abort_cnt: xfer_cnt=%h required %h", xfer_cnt, exp_cnt); end
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack: ack=%b required 0", bus.ack); end
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL abort_valid: out_valid=%b required 1", bus.out_valid); end
    if (bus.out_data !== 8'h11) begin n_bad++; $display("FAIL abort_head: out_data=%h required 11", bus.out_data); end
  endtask

  task automatic test_full_push_pop();
    int t;
    bus.data = 8'h44;
    bus.req  = 1'b1;
    tick(2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp += 3;
    if (bus.ack !== 1'b1) begin
      n_bad++;
      $display("FAIL fpp_ack: ack=%b required 1", bus.ack);
    end else begin
      exp_q.push_back(8'h44);
    end
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_valid: out_valid=%b required 1", bus.out_valid); end
    if (bus.out_data !== 8'h22) begin n_bad++; $display("FAIL fpp_head: out_data=%h required 22", bus.out_data); end
    bus.req = 1'b0;
    t = 0;
    while (bus.ack !== 1'b0 && t < 50) begin
      tick();
      t++;
    end
    exp_cnt = exp_cnt + 16'd1;
    // Two words still held means a further request must be backpressured.
    bus.data = 8'h66;
    bus.req  = 1'b1;
    tick(8);
    n_cmp++;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL fpp_still_full: ack=%b required 0", bus.ack); end
    bus.out_ready = 1'b1;
    do_hs(8'h66);
    tick(6);
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL fpp_drain: %0d words outstanding, required 0", exp_q.size()); end
    if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL fpp_cnt: xfer_cnt=%h required %h", xfer_cnt, exp_cnt); end
    if (err !== exp_err) begin n_bad++; $display("FAIL fpp_err_sticky: err=%b required %b", err, exp_err); end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.out_ready = 1'b0;
    bus.data = 8'h55;
    bus.req  = 1'b1;
    t = 0;
    tick();
    while (bus.ack !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    exp_q.push_back(8'h55);
    tick(3);
    n_cmp++;
    if (bus.ack !== 1'b1) begin n_bad++; $display("FAIL rmid_ack_before: ack=%b required 1", bus.ack); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 16'd0;
    exp_err = 1'b0;
    n_cmp += 5;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack: ack=%b required 0", bus.ack); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: out_valid=%b required 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: out_data=%h required 00", bus.out_data); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err: err=%b required 0", err); end
    if (xfer_cnt !== 16'h0000) begin n_bad++; $display("FAIL rmid_cnt: xfer_cnt=%h required 0000", xfer_cnt); end
    bus.req = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    n_cmp += 3;
    if (bus.ack !== 1'b0) begin n_bad++; $display("FAIL rmid_after_ack: ack=%b required 0", bus.ack); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_after_err: err=%b required 0", err); end
    if (xfer_cnt !== 16'h0000) begin n_bad++; $display("FAIL rmid_after_cnt: xfer_cnt=%h required 0000", xfer_cnt); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    force dut.xfer_cnt_q = 16'hFFFF;
    tick();
    release dut.xfer_cnt_q;
    exp_cnt = 16'hFFFF;
    tick();
    n_cmp++;
    if (xfer_cnt !== exp_cnt) begin n_bad++; $display("FAIL wrap_preload: xfer_cnt=%h required %h", xfer_cnt, exp_cnt); end
    bus.out_ready = 1'b1;
    d = 8'($urandom);
    do_hs(d);
    tick(3);
    n_cmp++;
    if (xfer_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_cnt: xfer_cnt=%h required 0000", xfer_cnt); end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          int gap;
          logic [7:0] d;
          gap = $urandom_range(0, 3);
          if (gap > 0) tick(gap);
          d = 8'($urandom);
          do_hs(d);
          n_cmp++;
          if (xfer_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL rnd_cnt: xfer_cnt=%h required %h at handshake %0d", xfer_cnt, exp_cnt, i);
          end
        end
        rnd_done = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    tick(6);
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: %0d words outstanding, required 0", exp_q.size()); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_empty: out_valid=%b required 0", bus.out_valid); end
    if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err: err=%b required %b", err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_full_push_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
